// File: rtl/ram_4r1w_rd_sched.sv
// Read-port scheduler for the replicated 4-read/1-write RAM: round-robin shares the
// four read ports among NREQ requesters, tracks reads through RD_LAT and returns data.
module ram_4r1w_rd_sched #(
    parameter int BLOCKSIZE = 10,
    parameter int NREQ      = 8,
    parameter int RD_LAT    = 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ*(BLOCKSIZE+1)-1:0]   req_addr,
    output logic [NREQ-1:0]                 req_ready,
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [NREQ*32-1:0]              rsp_data,
    input  logic                            wr_valid,
    input  logic [BLOCKSIZE:0]              wr_addr,
    input  logic [31:0]                     wr_data,
    output logic                            wr_ready,
    output logic                            ram_w_enb,
    output logic [BLOCKSIZE:0]              ram_w_addr,
    output logic [31:0]                     ram_w_din,
    output logic [BLOCKSIZE:0]              ram_r_addr_1,
    output logic [BLOCKSIZE:0]              ram_r_addr_2,
    output logic [BLOCKSIZE:0]              ram_r_addr_3,
    output logic [BLOCKSIZE:0]              ram_r_addr_4,
    input  logic [31:0]                     ram_r_dout_1,
    input  logic [31:0]                     ram_r_dout_2,
    input  logic [31:0]                     ram_r_dout_3,
    input  logic [31:0]                     ram_r_dout_4
);

    localparam int AW = BLOCKSIZE + 1;
    localparam int IW = $clog2(NREQ);

    logic [AW-1:0]   addr_arr [NREQ];
    logic [NREQ-1:0] eligible;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   ptr_next;
    logic [IW:0]     cand;
    logic [IW-1:0]   cand_i;
    logic [2:0]      n;
    logic [3:0]      port_vld;
    logic [IW-1:0]   port_idx  [4];
    logic [AW-1:0]   port_addr [4];
    logic [31:0]     dout      [4];
    logic [3:0]      pipe_vld  [RD_LAT];
    logic [IW-1:0]   pipe_idx  [RD_LAT][4];
    logic [31:0]     rsp_arr   [NREQ];

    assign wr_ready   = 1'b1;
    assign ram_w_enb  = wr_valid;
    assign ram_w_addr = wr_addr;
    assign ram_w_din  = wr_data;

    assign ram_r_addr_1 = port_addr[0];
    assign ram_r_addr_2 = port_addr[1];
    assign ram_r_addr_3 = port_addr[2];
    assign ram_r_addr_4 = port_addr[3];

    assign dout[0] = ram_r_dout_1;
    assign dout[1] = ram_r_dout_2;
    assign dout[2] = ram_r_dout_3;
    assign dout[3] = ram_r_dout_4;

    // A read of the address being written waits, so it issues after the write lands.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = req_addr[i*AW +: AW];
            eligible[i] = req_valid[i] && !(wr_valid && (addr_arr[i] == wr_addr));
        end
    end

    always_comb begin
        req_ready = '0;
        port_vld  = '0;
        ptr_next  = ptr;
        cand      = '0;
        cand_i    = '0;
        n         = '0;
        for (int k = 0; k < 4; k++) begin
            port_idx[k]  = '0;
            port_addr[k] = '0;
        end
        for (int j = 0; j < NREQ; j++) begin
            cand = {1'b0, ptr} + (IW+1)'(j);
            if (cand >= (IW+1)'(NREQ))
                cand = cand - (IW+1)'(NREQ);
            cand_i = cand[IW-1:0];
            if (eligible[cand_i] && (n < 3'd4)) begin
                req_ready[cand_i]   = 1'b1;
                port_vld[n[1:0]]    = 1'b1;
                port_idx[n[1:0]]    = cand_i;
                port_addr[n[1:0]]   = addr_arr[cand_i];
                ptr_next            = (cand_i == IW'(NREQ-1)) ? '0 : cand_i + 1'b1;
                n                   = n + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pipe_vld[s] <= '0;
                for (int k = 0; k < 4; k++)
                    pipe_idx[s][k] <= '0;
            end
        end else begin
            ptr         <= ptr_next;
            pipe_vld[0] <= port_vld;
            pipe_idx[0] <= port_idx;
            for (int s = 1; s < RD_LAT; s++) begin
                pipe_vld[s] <= pipe_vld[s-1];
                pipe_idx[s] <= pipe_idx[s-1];
            end
        end
    end

    // The last stage lines up with valid RAM data; each index appears on at most one port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid <= '0;
            for (int i = 0; i < NREQ; i++)
                rsp_arr[i] <= '0;
        end else begin
            rsp_valid <= '0;
            for (int k = 0; k < 4; k++) begin
                if (pipe_vld[RD_LAT-1][k]) begin
                    rsp_valid[pipe_idx[RD_LAT-1][k]] <= 1'b1;
                    rsp_arr[pipe_idx[RD_LAT-1][k]]   <= dout[k];
                end
            end
        end
    end

    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        assign rsp_data[i*32 +: 32] = rsp_arr[i];
    end

endmodule

// File: tb/tb_ram_4r1w_rd_sched.sv
// Scoreboard bench for ram_4r1w_rd_sched: two instances (RD_LAT 1 and 3) share stimulus,
// each with its own RAM model and response monitor.
module tb_ram_4r1w_rd_sched;

    localparam int BLOCKSIZE = 10;
    localparam int NREQ      = 8;
    localparam int AW        = BLOCKSIZE + 1;
    localparam int NINST     = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic               wr_valid;
    logic [AW-1:0]      wr_addr;
    logic [31:0]        wr_data;

    logic [NREQ-1:0]    req_ready_w   [NINST];
    logic [NREQ-1:0]    rsp_valid_w   [NINST];
    logic [NREQ*32-1:0] rsp_data_w    [NINST];
    logic               wr_ready_w    [NINST];
    logic               ram_w_enb_w   [NINST];
    logic [AW-1:0]      ram_w_addr_w  [NINST];
    logic [31:0]        ram_w_din_w   [NINST];
    logic [AW-1:0]      r_addr_w      [NINST][4];

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected data and grant cycle per (instance, requester).
    logic [31:0] exp_d [NINST*NREQ][$];
    int          exp_t [NINST*NREQ][$];
    logic [31:0] ref_mem [2**AW];
    int          ref_ptr = 0;

    function automatic logic [31:0] init_word(int a);
        return 32'hDEAD0000 | 32'(a);
    endfunction

    for (genvar g = 0; g < NINST; g++) begin : inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem   [2**AW];
        logic [31:0] dpipe [L][4];
        logic [31:0] last_d [NREQ];

        ram_4r1w_rd_sched #(.BLOCKSIZE(BLOCKSIZE), .NREQ(NREQ), .RD_LAT(L)) dut (
            .clk          (clk),
            .rst          (rst),
            .req_valid    (req_valid),
            .req_addr     (req_addr),
            .req_ready    (req_ready_w[g]),
            .rsp_valid    (rsp_valid_w[g]),
            .rsp_data     (rsp_data_w[g]),
            .wr_valid     (wr_valid),
            .wr_addr      (wr_addr),
            .wr_data      (wr_data),
            .wr_ready     (wr_ready_w[g]),
            .ram_w_enb    (ram_w_enb_w[g]),
            .ram_w_addr   (ram_w_addr_w[g]),
            .ram_w_din    (ram_w_din_w[g]),
            .ram_r_addr_1 (r_addr_w[g][0]),
            .ram_r_addr_2 (r_addr_w[g][1]),
            .ram_r_addr_3 (r_addr_w[g][2]),
            .ram_r_addr_4 (r_addr_w[g][3]),
            .ram_r_dout_1 (dpipe[L-1][0]),
            .ram_r_dout_2 (dpipe[L-1][1]),
            .ram_r_dout_3 (dpipe[L-1][2]),
            .ram_r_dout_4 (dpipe[L-1][3])
        );

        initial begin
            for (int a = 0; a < 2**AW; a++) mem[a] = init_word(a);
            for (int i = 0; i < NREQ; i++) last_d[i] = '0;
        end

        // RAM model: data sampled when the address is presented, delivered L cycles later.
        always @(posedge clk) begin
            for (int k = 0; k < 4; k++) dpipe[0][k] <= mem[r_addr_w[g][k]];
            for (int s = 1; s < L; s++) dpipe[s] <= dpipe[s-1];
            if (ram_w_enb_w[g]) mem[ram_w_addr_w[g]] <= ram_w_din_w[g];
        end

        always @(negedge clk) begin : monitor
            int          q;
            int          due;
            logic [31:0] got;
            logic [31:0] ev;
            if (!rst)
                for (int i = 0; i < NREQ; i++) last_d[i] = '0;
            for (int i = 0; i < NREQ; i++) begin
                q   = g*NREQ + i;
                got = rsp_data_w[g][i*32 +: 32];
                checks++;
                if (rsp_valid_w[g][i]) begin
                    if (exp_d[q].size() == 0) begin
                        errors++;
                        $display("[TB] FAIL rsp_unexpected lat=%0d req=%0d cyc=%0d got=%h expected no response", L, i, cyc, got);
                        last_d[i] = got;
                    end else begin
                        ev  = exp_d[q].pop_front();
                        due = exp_t[q].pop_front() + L + 1;
                        if (got !== ev || cyc != due) begin
                            errors++;
                            $display("[TB] FAIL rsp_data lat=%0d req=%0d got=%h@%0d expected=%h@%0d", L, i, got, cyc, ev, due);
                        end
                        last_d[i] = ev;
                    end
                end else if (exp_t[q].size() != 0 && exp_t[q][0] + L + 1 <= cyc) begin
                    errors++;
                    $display("[TB] FAIL rsp_missing lat=%0d req=%0d cyc=%0d got=no response expected=%h", L, i, cyc, exp_d[q][0]);
                    void'(exp_d[q].pop_front());
                    void'(exp_t[q].pop_front());
                end else if (got !== last_d[i]) begin
                    errors++;
                    $display("[TB] FAIL rsp_hold lat=%0d req=%0d got=%h expected=%h", L, i, got, last_d[i]);
                end
            end
        end
    end

    task automatic check_output(input string name, input int g, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s inst=%0d got=%h expected=%h", name, g, got, exp);
        end
    endtask

    task automatic flush_model();
        for (int q = 0; q < NINST*NREQ; q++) begin
            exp_d[q].delete();
            exp_t[q].delete();
        end
        ref_ptr = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst       = 1'b0;
        req_valid = '0;
        wr_valid  = 1'b0;
        flush_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < NINST; g++) begin
            check_output("rst_rsp_valid", g, 64'(rsp_valid_w[g]), 64'd0);
            check_output("rst_rsp_data_zero", g, 64'(rsp_data_w[g] == '0), 64'd1);
        end
    endtask

    task automatic apply_stimulus(input logic [NREQ-1:0] v, input logic [AW-1:0] a [NREQ],
                                  input logic wv, input logic [AW-1:0] wa, input logic [31:0] wd,
                                  input logic chk_en, input logic [NREQ-1:0] chk_ready);
        int              granted[$];
        logic [NREQ-1:0] exp_ready;
        logic [AW-1:0]   exp_port [4];
        int              c;
        int              grant_cyc;
        @(negedge clk);
        req_valid = v;
        for (int i = 0; i < NREQ; i++) req_addr[i*AW +: AW] = a[i];
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        #1;
        exp_ready = '0;
        for (int j = 0; j < NREQ; j++) begin
            c = (ref_ptr + j) % NREQ;
            if (v[c] && !(wv && a[c] == wa) && granted.size() < 4) begin
                granted.push_back(c);
                exp_ready[c] = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) exp_port[k] = (k < granted.size()) ? a[granted[k]] : '0;
        for (int g = 0; g < NINST; g++) begin
            check_output("req_ready", g, 64'(req_ready_w[g]), 64'(exp_ready));
            if (chk_en) check_output("req_ready_directed", g, 64'(req_ready_w[g]), 64'(chk_ready));
            for (int k = 0; k < 4; k++)
                check_output($sformatf("ram_r_addr_%0d", k+1), g, 64'(r_addr_w[g][k]), 64'(exp_port[k]));
            check_output("wr_ready", g, 64'(wr_ready_w[g]), 64'd1);
            check_output("ram_w_enb", g, 64'(ram_w_enb_w[g]), 64'(wv));
            if (wv) begin
                check_output("ram_w_addr", g, 64'(ram_w_addr_w[g]), 64'(wa));
                check_output("ram_w_din", g, 64'(ram_w_din_w[g]), 64'(wd));
            end
        end
        grant_cyc = cyc;
        if (rst) begin
            foreach (granted[m])
                for (int g = 0; g < NINST; g++) begin
                    exp_d[g*NREQ + granted[m]].push_back(ref_mem[a[granted[m]]]);
                    exp_t[g*NREQ + granted[m]].push_back(grant_cyc);
                end
        end
        @(posedge clk);
        if (rst && granted.size() > 0) ref_ptr = (granted[granted.size()-1] + 1) % NREQ;
        if (wv) ref_mem[wa] = wd;
    endtask

    logic [AW-1:0] addrs [NREQ];

    task automatic idle(input int n);
        logic [AW-1:0] z [NREQ];
        for (int i = 0; i < NREQ; i++) z[i] = '0;
        repeat (n) apply_stimulus('0, z, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        wr_valid  = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        for (int a = 0; a < 2**AW; a++) ref_mem[a] = init_word(a);
        for (int i = 0; i < NREQ; i++) addrs[i] = '0;

        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int g = 0; g < NINST; g++) begin
            check_output("reset_rsp_valid", g, 64'(rsp_valid_w[g]), 64'd0);
            check_output("reset_rsp_data_zero", g, 64'(rsp_data_w[g] == '0), 64'd1);
        end

        $display("[TB] single read from requester 3");
        addrs[3] = 11'h005;
        apply_stimulus(8'b0000_1000, addrs, 1'b0, '0, '0, 1'b1, 8'b0000_1000);
        idle(5);

        $display("[TB] all requesters valid");
        do_reset();
        for (int i = 0; i < NREQ; i++) addrs[i] = AW'(11'h100 + i);
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'h0F);
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'hF0);
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'h0F);
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'hF0);

        $display("[TB] wrap-around scan from pointer 5");
        apply_stimulus(8'h1F, addrs, 1'b0, '0, '0, 1'b1, 8'h0F);
        apply_stimulus(8'h10, addrs, 1'b0, '0, '0, 1'b1, 8'h10);
        apply_stimulus(8'b0100_0110, addrs, 1'b0, '0, '0, 1'b1, 8'b0100_0110);
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'b0111_1000);
        idle(5);

        $display("[TB] write hazard");
        addrs[0] = 11'h040;
        addrs[1] = 11'h041;
        apply_stimulus(8'b11, addrs, 1'b1, 11'h040, 32'h12345678, 1'b1, 8'b10);
        apply_stimulus(8'b01, addrs, 1'b0, '0, '0, 1'b1, 8'b01);
        idle(5);

        $display("[TB] reset with reads in flight");
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b0, '0);
        do_reset();
        apply_stimulus(8'hFF, addrs, 1'b0, '0, '0, 1'b1, 8'h0F);
        idle(5);

        $display("[TB] back-to-back reads from requester 2");
        for (int k = 0; k < 4; k++) begin
            addrs[2] = AW'(k);
            apply_stimulus(8'b0000_0100, addrs, 1'b0, '0, '0, 1'b1, 8'b0000_0100);
        end
        idle(6);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            logic [NREQ-1:0] v;
            logic            wv;
            v  = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) addrs[i] = AW'($urandom_range(0, 15));
            wv = ($urandom_range(0, 2) == 0);
            apply_stimulus(v, addrs, wv, AW'($urandom_range(0, 15)), $urandom, 1'b0, '0);
        end
        idle(6);

        for (int q = 0; q < NINST*NREQ; q++) begin
            checks++;
            if (exp_d[q].size() != 0) begin
                errors++;
                $display("[TB] FAIL drain inst=%0d req=%0d got=%0d outstanding expected=0", q / NREQ, q % NREQ, exp_d[q].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog got=timeout expected=completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
